// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage: PC, IF/ID register, one outstanding
//               imem request with a single-entry response buffer.
//               Optional macro FETCH_PERF_CNT_EN adds stall/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_pc,
    input  logic            en_IF,
    input  logic            flush,
    input  logic            branchTaken,
    input  logic [XLEN-1:0] branchTarget,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic            imemValid,
    input  logic [31:0]     imemRdata,
    output logic            ifidValid,
    output logic [XLEN-1:0] ifidPc,
    output logic [31:0]     ifidInstr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetchStallCnt,
    output logic [31:0]     fetchDropCnt
`endif
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_REQ  = 3'd1;
    localparam logic [2:0] c_WAIT = 3'd2;
    localparam logic [2:0] c_HOLD = 3'd3;
    localparam logic [2:0] c_DROP = 3'd4;

    localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(4);

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_reqPc;
    logic [31:0]     r_bufInstr;
    logic            r_ifidValid;
    logic [XLEN-1:0] r_ifidPc;
    logic [31:0]     r_ifidInstr;

    logic [2:0]      w_stateNext;
    logic            w_accept;
    logic            w_ifidFree;
    logic            w_load;
    logic            w_toHold;
    logic [31:0]     w_loadInstr;

    // A redirect in REQ withdraws the request so no stale fetch is ever accepted.
    assign imemReq    = (r_state == c_REQ) && !branchTaken;
    assign imemAddr   = r_pc;
    assign w_accept   = imemReq && imemReady;
    assign w_ifidFree = en_IF && !flush;

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_toHold    = 1'b0;
        w_loadInstr = r_bufInstr;
        case (r_state)
            c_IDLE: w_stateNext = c_REQ;
            c_REQ: begin
                if (w_accept) w_stateNext = c_WAIT;
            end
            c_WAIT: begin
                // A response arriving together with a redirect is killed on the spot.
                if (branchTaken) begin
                    w_stateNext = imemValid ? c_REQ : c_DROP;
                end else if (imemValid) begin
                    if (w_ifidFree) begin
                        w_load      = 1'b1;
                        w_loadInstr = imemRdata;
                        w_stateNext = c_REQ;
                    end else begin
                        w_toHold    = 1'b1;
                        w_stateNext = c_HOLD;
                    end
                end
            end
            c_HOLD: begin
                if (branchTaken) begin
                    w_stateNext = c_REQ;
                end else if (w_ifidFree) begin
                    w_load      = 1'b1;
                    w_stateNext = c_REQ;
                end
            end
            c_DROP: begin
                if (imemValid) w_stateNext = c_REQ;
            end
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_pc        <= RESET_PC;
            r_reqPc     <= '0;
            r_bufInstr  <= NOP_INSTR;
            r_ifidValid <= 1'b0;
            r_ifidPc    <= '0;
            r_ifidInstr <= NOP_INSTR;
        end else begin
            r_state <= w_stateNext;
            if (branchTaken) begin
                r_pc <= branchTarget & c_ALIGN_MASK;
            end else if (w_load && en_pc) begin
                r_pc <= r_pc + c_PC_STEP;
            end
            if (w_accept) r_reqPc <= r_pc;
            if (w_toHold) r_bufInstr <= imemRdata;
            // With en_IF open and nothing arriving, decode receives a bubble.
            if (flush) begin
                r_ifidValid <= 1'b0;
                r_ifidInstr <= NOP_INSTR;
            end else if (en_IF) begin
                if (w_load) begin
                    r_ifidValid <= 1'b1;
                    r_ifidPc    <= r_reqPc;
                    r_ifidInstr <= w_loadInstr;
                end else begin
                    r_ifidValid <= 1'b0;
                    r_ifidInstr <= NOP_INSTR;
                end
            end
        end
    end

    assign ifidValid = r_ifidValid;
    assign ifidPc    = r_ifidPc;
    assign ifidInstr = r_ifidInstr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_dropCnt;
    logic        w_stallEvt;
    logic        w_dropEvt;

    assign w_stallEvt = (r_state == c_HOLD) || ((r_state == c_REQ) && !en_pc);
    assign w_dropEvt  = ((r_state == c_DROP) && imemValid)
                     || ((r_state == c_HOLD) && branchTaken)
                     || ((r_state == c_WAIT) && imemValid && branchTaken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
            r_dropCnt  <= '0;
        end else begin
            if (w_stallEvt && (r_stallCnt != 32'hFFFF_FFFF)) r_stallCnt <= r_stallCnt + 32'd1;
            if (w_dropEvt && (r_dropCnt != 32'hFFFF_FFFF))   r_dropCnt  <= r_dropCnt + 32'd1;
        end
    end

    assign fetchStallCnt = r_stallCnt;
    assign fetchDropCnt  = r_dropCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed vector table, reset sequence and randomized run of
//               fetch_unit against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_NOP  = 32'h0000_0013;
    localparam logic [31:0] c_ADDI = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        rst_n, en_pc, en_IF, flush, branchTaken, imemReady, imemValid;
    logic [31:0] branchTarget, imemRdata;
    logic        imemReq, ifidValid, imemReq2, ifidValid2;
    logic [31:0] imemAddr, ifidPc, ifidInstr, imemAddr2, ifidPc2, ifidInstr2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchStallCnt, fetchDropCnt, fetchStallCnt2, fetchDropCnt2;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .en_pc(en_pc), .en_IF(en_IF), .flush(flush),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
        .imemValid(imemValid), .imemRdata(imemRdata),
        .ifidValid(ifidValid), .ifidPc(ifidPc), .ifidInstr(ifidInstr)
`ifdef FETCH_PERF_CNT_EN
        , .fetchStallCnt(fetchStallCnt), .fetchDropCnt(fetchDropCnt)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst_n(rst_n), .en_pc(en_pc), .en_IF(en_IF), .flush(flush),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imemReq(imemReq2), .imemAddr(imemAddr2), .imemReady(imemReady),
        .imemValid(imemValid), .imemRdata(imemRdata),
        .ifidValid(ifidValid2), .ifidPc(ifidPc2), .ifidInstr(ifidInstr2)
`ifdef FETCH_PERF_CNT_EN
        , .fetchStallCnt(fetchStallCnt2), .fetchDropCnt(fetchDropCnt2)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy, vld, enPc, enIf, fl, br;
        logic [31:0] rdata, tgt;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc, expInstr;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic vld, input logic [31:0] rd,
                                input logic ep, input logic ei, input logic fl, input logic br,
                                input logic [31:0] tg, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] epc, input logic [31:0] ein);
        vec_t v;
        v.rdy = rdy; v.vld = vld; v.rdata = rd; v.enPc = ep; v.enIf = ei; v.fl = fl;
        v.br = br; v.tgt = tg; v.expReq = er; v.expAddr = ea; v.expValid = ev;
        v.expPc = epc; v.expInstr = ein;
        return v;
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    vec_t vecs [28];

    // Transaction-level reference: occupancy of the single outstanding slot and buffer.
    logic        mStarted, mOut, mKilled, expReq, free, enter;
    logic [31:0] mPc, mReqPc, enterPc, enterInstr, eInstr, ePc;
    logic        eValid;
    logic [31:0] bufQ [$];
    logic        pend;
    logic [31:0] pendAddr;
    int          pendDelay;

    task automatic applyReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en_pc = 1'b1; en_IF = 1'b1; flush = 1'b0; branchTaken = 1'b0;
        branchTarget = '0; imemReady = 1'b0; imemValid = 1'b0; imemRdata = '0;

        vecs[0]  = mk(1,0,0,            1,1,0,0,0,            0,32'h000, 0,32'h000,c_NOP);
        vecs[1]  = mk(1,0,0,            1,1,0,0,0,            1,32'h000, 0,32'h000,c_NOP);
        vecs[2]  = mk(1,1,c_ADDI,       1,1,0,0,0,            0,32'h000, 1,32'h000,c_ADDI);
        vecs[3]  = mk(1,0,0,            1,1,0,0,0,            1,32'h004, 0,32'h000,c_NOP);
        vecs[4]  = mk(1,1,c_ADDI,       1,1,0,0,0,            0,32'h004, 1,32'h004,c_ADDI);
        vecs[5]  = mk(1,0,0,            0,0,0,0,0,            1,32'h008, 1,32'h004,c_ADDI);
        vecs[6]  = mk(1,1,32'h33,       0,0,0,0,0,            0,32'h008, 1,32'h004,c_ADDI);
        vecs[7]  = mk(1,0,0,            0,0,0,0,0,            0,32'h008, 1,32'h004,c_ADDI);
        vecs[8]  = mk(1,0,0,            0,0,0,0,0,            0,32'h008, 1,32'h004,c_ADDI);
        vecs[9]  = mk(1,0,0,            0,0,0,0,0,            0,32'h008, 1,32'h004,c_ADDI);
        vecs[10] = mk(1,0,0,            1,1,0,0,0,            0,32'h008, 1,32'h008,32'h33);
        vecs[11] = mk(1,0,0,            1,1,0,0,0,            1,32'h00C, 0,32'h008,c_NOP);
        vecs[12] = mk(1,0,0,            1,1,0,1,32'h102,      0,32'h00C, 0,32'h008,c_NOP);
        vecs[13] = mk(1,1,32'hDEADBEEF, 1,1,0,0,0,            0,32'h100, 0,32'h008,c_NOP);
        vecs[14] = mk(0,0,0,            1,1,0,0,0,            1,32'h100, 0,32'h008,c_NOP);
        vecs[15] = mk(1,0,0,            1,1,0,0,0,            1,32'h100, 0,32'h008,c_NOP);
        vecs[16] = mk(1,1,32'h533,      1,1,1,0,0,            0,32'h100, 0,32'h008,c_NOP);
        vecs[17] = mk(1,0,0,            1,1,0,0,0,            0,32'h100, 1,32'h100,32'h533);
        vecs[18] = mk(1,0,0,            1,1,0,0,0,            1,32'h104, 0,32'h100,c_NOP);
        vecs[19] = mk(1,1,32'h633,      0,1,0,0,0,            0,32'h104, 1,32'h104,32'h633);
        vecs[20] = mk(0,0,0,            1,1,0,0,0,            1,32'h104, 0,32'h104,c_NOP);
        vecs[21] = mk(1,0,0,            1,1,0,1,32'h203,      0,32'h104, 0,32'h104,c_NOP);
        vecs[22] = mk(1,0,0,            1,1,0,0,0,            1,32'h200, 0,32'h104,c_NOP);
        vecs[23] = mk(1,1,32'h733,      1,1,0,1,32'h300,      0,32'h200, 0,32'h104,c_NOP);
        vecs[24] = mk(1,0,0,            1,1,0,0,0,            1,32'h300, 0,32'h104,c_NOP);
        vecs[25] = mk(1,1,32'h833,      0,0,0,0,0,            0,32'h300, 0,32'h104,c_NOP);
        vecs[26] = mk(1,0,0,            1,1,0,1,32'h400,      0,32'h300, 0,32'h104,c_NOP);
        vecs[27] = mk(0,0,0,            1,1,0,0,0,            1,32'h400, 0,32'h104,c_NOP);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check1 ("reset.req",   imemReq,   1'b0);
        check1 ("reset.valid", ifidValid, 1'b0);
        check32("reset.pc",    ifidPc,    32'h0);
        check32("reset.instr", ifidInstr, c_NOP);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            imemReady = vecs[i].rdy; imemValid = vecs[i].vld; imemRdata = vecs[i].rdata;
            en_pc = vecs[i].enPc; en_IF = vecs[i].enIf; flush = vecs[i].fl;
            branchTaken = vecs[i].br; branchTarget = vecs[i].tgt;
            #1;
            check1($sformatf("vec%0d.req", i), imemReq, vecs[i].expReq);
            if (vecs[i].expReq) begin
                check32($sformatf("vec%0d.addr", i), imemAddr, vecs[i].expAddr);
                check32($sformatf("vec%0d.wrapAddr", i), imemAddr2,
                        (i <= 12) ? vecs[i].expAddr - 32'd4 : vecs[i].expAddr);
            end
            @(posedge clk); #1;
            check1 ($sformatf("vec%0d.ifidValid", i), ifidValid, vecs[i].expValid);
            check32($sformatf("vec%0d.ifidPc", i),    ifidPc,    vecs[i].expPc);
            check32($sformatf("vec%0d.ifidInstr", i), ifidInstr, vecs[i].expInstr);
            @(negedge clk);
        end
`ifdef FETCH_PERF_CNT_EN
        check32("perf.dropCnt",  fetchDropCnt,  32'd3);
        check32("perf.stallCnt", fetchStallCnt, 32'd7);
`endif

        // Reset while a fetch is outstanding; its late response must be ignored.
        imemReady = 1'b1; imemValid = 1'b0; en_pc = 1'b1; en_IF = 1'b1;
        flush = 1'b0; branchTaken = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check1 ("midRst.req",   imemReq,   1'b0);
        check1 ("midRst.valid", ifidValid, 1'b0);
        check32("midRst.pc",    ifidPc,    32'h0);
        check32("midRst.instr", ifidInstr, c_NOP);
        check32("midRst.addr",  imemAddr,  32'h0);
        @(negedge clk);
        rst_n = 1'b1; imemReady = 1'b0; imemValid = 1'b1; imemRdata = 32'h0BAD_0033;
        @(posedge clk); #1;
        check1("late.idleValid", ifidValid, 1'b0);
        @(negedge clk); #1;
        check1 ("late.req",      imemReq,   1'b1);
        check32("late.addr",     imemAddr,  32'h0);
        check32("late.wrapAddr", imemAddr2, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check1("late.reqValid", ifidValid, 1'b0);
        @(negedge clk);
        imemValid = 1'b0; imemReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imemValid = 1'b1; imemRdata = 32'h00A0_0113; #1;
        check1("late.waitReq", imemReq, 1'b0);
        @(posedge clk); #1;
        check1 ("late.ifidValid", ifidValid, 1'b1);
        check32("late.ifidPc",    ifidPc,    32'h0);
        check32("late.ifidInstr", ifidInstr, 32'h00A0_0113);
        @(negedge clk);

        // Randomized run against the reference model.
        imemValid = 1'b0;
        applyReset();
        mStarted = 1'b0; mOut = 1'b0; mKilled = 1'b0; mPc = 32'h0; mReqPc = 32'h0;
        bufQ.delete(); eValid = 1'b0; ePc = 32'h0; eInstr = c_NOP; pend = 1'b0;
        pendAddr = 32'h0; pendDelay = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (pend && pendDelay == 0) begin
                imemValid = 1'b1; imemRdata = memWord(pendAddr); pend = 1'b0;
            end else begin
                if (pend) pendDelay--;
                imemValid = !pend && ($urandom % 32 == 0);
                imemRdata = $urandom;
            end
            en_IF = ($urandom % 5 != 0);
            en_pc = ($urandom % 10 == 0) ? !en_IF : en_IF;
            flush = ($urandom % 10 == 0);
            branchTaken = ($urandom % 12 == 0);
            branchTarget = $urandom;
            imemReady = ($urandom % 4 != 0);
            #1;
            expReq = mStarted && !mOut && (bufQ.size() == 0) && !branchTaken;
            check1("rand.req", imemReq, expReq);
            if (expReq) check32("rand.addr", imemAddr, mPc);

            free = en_IF && !flush;
            enter = 1'b0; enterInstr = c_NOP; enterPc = mReqPc;
            if (imemValid && mOut) begin
                mOut = 1'b0;
                if (!(mKilled || branchTaken)) begin
                    if (free) begin enter = 1'b1; enterInstr = imemRdata; end
                    else bufQ.push_back(imemRdata);
                end
            end else if (bufQ.size() != 0) begin
                if (branchTaken) bufQ.delete();
                else if (free) begin enter = 1'b1; enterInstr = bufQ.pop_front(); end
            end else if (mOut && branchTaken) begin
                mKilled = 1'b1;
            end
            if (expReq && imemReady) begin
                mOut = 1'b1; mKilled = 1'b0; mReqPc = mPc;
                pend = 1'b1; pendAddr = mPc; pendDelay = $urandom_range(0, 2);
            end
            if (branchTaken) mPc = {branchTarget[31:2], 2'b00};
            else if (enter && en_pc) mPc = mPc + 32'd4;
            if (flush) begin
                eValid = 1'b0; eInstr = c_NOP;
            end else if (en_IF) begin
                if (enter) begin eValid = 1'b1; ePc = enterPc; eInstr = enterInstr; end
                else begin eValid = 1'b0; eInstr = c_NOP; end
            end
            mStarted = 1'b1;

            @(posedge clk); #1;
            check1 ("rand.ifidValid", ifidValid, eValid);
            check32("rand.ifidPc",    ifidPc,    ePc);
            check32("rand.ifidInstr", ifidInstr, eInstr);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
